// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared types and helpers for the HyperBus transaction scheduler
package hyperbus_pkg;

  // Descriptor fields are stored at their widest supported size and zero-padded.
  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxLenWidth  = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StGap   = 2'd3
  } hyper_sched_state_t;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxLenWidth-1:0]  len;
    logic [2:0]              size;
    logic                    write;
  } hyper_trans_desc_t;

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req == 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/hyperbus_trans_sched_if.sv
// rtl/hyperbus_trans_sched_if.sv - requester and PHY command-channel bundle of the scheduler
interface hyperbus_trans_sched_if
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned BurstLength = 8,
  parameter int unsigned IdWidth     = id_width(NumReq)
);

  logic [NumReq-1:0]             req_valid_i;
  logic [NumReq-1:0]             req_ready_o;
  logic [NumReq*AddrWidth-1:0]   req_addr_i;
  logic [NumReq*BurstLength-1:0] req_len_i;
  logic [NumReq*3-1:0]           req_size_i;
  logic [NumReq-1:0]             req_write_i;

  logic                          trans_valid_o;
  logic                          trans_ready_i;
  logic                          trans_handshake_o;
  logic [AddrWidth-1:0]          start_addr_o;
  logic [BurstLength-1:0]        burst_len_o;
  logic [2:0]                    size_o;
  logic                          is_a_read_o;
  logic [IdWidth-1:0]            grant_id_o;
  logic                          done_i;
  logic                          busy_o;
  logic                          timeout_o;

  // slave: the scheduler itself; master: requesters plus PHY driving it.
  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_size_i, req_write_i,
    input  trans_ready_i, done_i,
    output req_ready_o, trans_valid_o, trans_handshake_o, start_addr_o,
    output burst_len_o, size_o, is_a_read_o, grant_id_o, busy_o, timeout_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_size_i, req_write_i,
    output trans_ready_i, done_i,
    input  req_ready_o, trans_valid_o, trans_handshake_o, start_addr_o,
    input  burst_len_o, size_o, is_a_read_o, grant_id_o, busy_o, timeout_o
  );

endinterface

// File: rtl/hyperbus_rr_arb.sv
// rtl/hyperbus_rr_arb.sv - combinational round-robin picker; the caller owns the last pointer
module hyperbus_rr_arb #(
  parameter int unsigned NumReq  = 2,
  parameter int unsigned IdWidth = 1
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] last_i,
  output logic [NumReq-1:0]  gnt_o,
  output logic [IdWidth-1:0] gnt_id_o,
  output logic               any_o
);

  logic found;

  assign any_o = |req_i;

  // Visit last+1, last+2, ... with wrap; the first pending requester wins.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (!found && req_i[k] && (k == (32'(last_i) + off) % NumReq)) begin
          found    = 1'b1;
          gnt_o[k] = 1'b1;
          gnt_id_o = IdWidth'(k);
        end
      end
    end
  end

endmodule

// File: rtl/hyperbus_trans_sched.sv
// rtl/hyperbus_trans_sched.sv - one-at-a-time HyperBus transaction scheduler with watchdog and CS-high gap
module hyperbus_trans_sched
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned BurstLength   = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned MinGap        = 2
) (
  input logic                   clk_i,
  input logic                   rst_i,
  hyperbus_trans_sched_if.slave bus
);

  localparam int unsigned IdWidth  = id_width(NumReq);
  localparam int unsigned WdWidth  = $clog2(TimeoutCycles) + 1;
  localparam int unsigned GapWidth = (MinGap == 0) ? 1 : $clog2(MinGap + 1);
  localparam hyper_sched_state_t ExitState = (MinGap == 0) ? StIdle : StGap;

  hyper_sched_state_t  state_q;
  logic [IdWidth-1:0]  last_q;
  logic [IdWidth-1:0]  grant_id_q;
  hyper_trans_desc_t   desc_q;
  hyper_trans_desc_t   desc_d;
  logic [WdWidth-1:0]  wd_q;
  logic [GapWidth-1:0] gap_q;
  logic                trans_valid_q;
  logic                timeout_q;

  logic [NumReq-1:0]   arb_gnt;
  logic [IdWidth-1:0]  arb_id;
  logic                arb_any;

  hyperbus_rr_arb #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_arb (
    .req_i    (bus.req_valid_i),
    .last_i   (last_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id),
    .any_o    (arb_any)
  );

  always_comb begin
    desc_d = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (arb_gnt[k]) begin
        desc_d.addr[AddrWidth-1:0]  = bus.req_addr_i[k*AddrWidth +: AddrWidth];
        desc_d.len[BurstLength-1:0] = bus.req_len_i[k*BurstLength +: BurstLength];
        desc_d.size                 = bus.req_size_i[k*3 +: 3];
        desc_d.write                = bus.req_write_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      last_q        <= IdWidth'(NumReq - 1);
      grant_id_q    <= '0;
      desc_q        <= '0;
      wd_q          <= '0;
      gap_q         <= '0;
      trans_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            desc_q        <= desc_d;
            grant_id_q    <= arb_id;
            last_q        <= arb_id;
            trans_valid_q <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          if (bus.trans_ready_i) begin
            trans_valid_q <= 1'b0;
            wd_q          <= '0;
            state_q       <= StWait;
          end
        end
        StWait: begin
          if (wd_q != '1) begin
            wd_q <= wd_q + 1'b1;
          end
          gap_q <= GapWidth'(1);
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (bus.done_i) begin
            state_q <= ExitState;
          end else if (wd_q == WdWidth'(TimeoutCycles - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ExitState;
          end
        end
        StGap: begin
          if (gap_q >= GapWidth'(MinGap)) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready_o       = (state_q == StIdle && !rst_i) ? arb_gnt : '0;
  assign bus.trans_valid_o     = trans_valid_q;
  assign bus.trans_handshake_o = trans_valid_q & bus.trans_ready_i;
  assign bus.start_addr_o      = desc_q.addr[AddrWidth-1:0];
  assign bus.burst_len_o       = desc_q.len[BurstLength-1:0];
  assign bus.size_o            = desc_q.size;
  assign bus.is_a_read_o       = ~desc_q.write;
  assign bus.grant_id_o        = grant_id_q;
  assign bus.busy_o            = (state_q != StIdle);
  assign bus.timeout_o         = timeout_q;

  // Zero padding above AddrWidth/BurstLength is never read out.
  logic unused_desc_bits;
  assign unused_desc_bits = ^desc_q;

endmodule

// File: doc/hyperbus_trans_sched.md
# hyperbus_trans_sched

Transaction scheduler in front of the HyperBus PHY command channel. It arbitrates round-robin between `NumReq` transaction requesters (AXI read/write front ends) and issues one descriptor at a time to the PHY and the read splitter, using `trans_handshake_o`, `size_o`, `start_addr_o` and `burst_len_o`. It then holds off the next transaction until the current one reports completion or times out, and enforces a minimum inter-transaction gap (chip-select high time).

## Interface
- `NumReq`, default 2: number of requesters, ≥1.
- `AddrWidth`, default 32: transaction byte-address width.
- `BurstLength`, default 8: burst-length field width (AXI len, beats−1).
- `TimeoutCycles`, default 1024: Wait-state watchdog limit, ≥2.
- `MinGap`, default 2: idle cycles enforced after each transaction, ≥0.
- `clk_i`, in, 1: clock. The block uses one clock.
- `rst_i`, in, 1: reset. It is synchronous and active-high.
- `req_valid_i`, in, NumReq: request pending, one bit per requester.
- `req_ready_o`, out, NumReq: one-hot acceptance pulse.
- `req_addr_i`, in, NumReq*AddrWidth: start address. Requester k occupies slice `[k*AddrWidth +: AddrWidth]`.
- `req_len_i`, in, NumReq*BurstLength: burst length, packed the same way.
- `req_size_i`, in, NumReq*3: AXI size, packed the same way.
- `req_write_i`, in, NumReq: 1 = write, 0 = read.
- `trans_valid_o`, out, 1: descriptor valid toward PHY.
- `trans_ready_i`, in, 1: PHY accepts descriptor.
- `trans_handshake_o`, out, 1: `trans_valid_o & trans_ready_i`.
- `start_addr_o`, out, AddrWidth: latched start address.
- `burst_len_o`, out, BurstLength: latched burst length.
- `size_o`, out, 3: latched size.
- `is_a_read_o`, out, 1: `~latched write bit`.
- `grant_id_o`, out, IdWidth: index of the owning requester.
- `done_i`, in, 1: completion. This is the last read beat accepted or the write response.
- `busy_o`, out, 1: state ≠ Idle.
- `timeout_o`, out, 1: one-cycle pulse when the watchdog expires.

## Operation
- States are Idle, Issue, Wait and Gap, in a 2-bit encoded enum.
- **Idle.** If any `req_valid_i` bit is set:
  - Search for a winner starting at `(last_q+1) mod NumReq` and going upward with wrap.
  - Assert `req_ready_o[winner]` combinationally in the same cycle.
  - Latch that requester's address, length, size and write fields, and set `grant_id`.
  - Set `last_q` to the winner and go to Issue.
- **Issue.** Assert `trans_valid_o`. The descriptor outputs stay stable until `trans_ready_i`. On handshake, clear the watchdog counter and go to Wait.
- **Wait.** The watchdog counter increments every cycle.
  - If `done_i` is set, go to Gap.
  - Otherwise, if the counter equals `TimeoutCycles−1`, pulse `timeout_o` and go to Gap.
- **Gap.** The gap counter counts to `MinGap`, then returns to Idle. If `MinGap==0`, Wait exits directly to Idle.
- The watchdog counter is `$clog2(TimeoutCycles)+1` bits wide and saturates, with no wrap. The gap counter is `$clog2(MinGap+1)` bits, minimum 1.
- A `done_i` outside Wait is ignored.
- A requester that drops `req_valid_i` before being granted loses nothing; arbitration re-evaluates every Idle cycle.

## Timing
- **Reset.** While `rst_i` is high at a clock edge, the block forces:
  - state = Idle, `last_q = NumReq−1` (so requester 0 wins first), counters 0;
  - all latched fields 0;
  - `trans_valid_o`, `req_ready_o`, `timeout_o` and `busy_o` all 0, and `is_a_read_o = 1`.
- Reset mid-transaction aborts immediately. No `timeout_o` pulse is produced.
- **Latency.**
  - Request accepted in Idle cycle N gives `trans_valid_o` high at N+1.
  - Handshake at cycle M gives Wait from M+1.
  - `done_i` at cycle D gives Gap from D+1 and Idle from D+1+MinGap.
  - The next grant can occur at cycle D+1+MinGap.
- If `done_i` and the watchdog limit coincide, done wins and `timeout_o` stays 0.
- With `NumReq==1`, `IdWidth` is 1 and `grant_id_o` is always 0.
- At most one transaction is outstanding, and `req_ready_o` is 0 in every state except Idle.

## Structure
- `hyperbus_pkg` holds:
  - the state enum `hyper_sched_state_t`;
  - the localparam function for `IdWidth` (`NumReq==1 ? 1 : $clog2(NumReq)`);
  - the packed `hyper_trans_desc_t` (addr, len, size, write).
- Sub-module `hyperbus_rr_arb`: a combinational round-robin picker. Its input is `req` plus the `last` pointer; its outputs are one-hot `gnt`, `gnt_id` and `any`. The scheduler owns the `last` register.

## Test plan
- **Single read.** Requester 0 with addr 0x100, len 3, size 2, write 0. Expect:
  - `req_ready_o=01` at cycle 1 and `trans_valid_o` at cycle 2;
  - with `trans_ready_i` held high, handshake at cycle 2 and `is_a_read_o=1`;
  - `done_i` at cycle 10, then `busy_o` low at cycle 13 (MinGap=2).
- **Round-robin fairness.** Both requesters are held valid continuously. Grants must alternate 0,1,0,1; no requester is granted twice in a row.
- **Back-pressure.** Hold `trans_ready_i` low for 5 cycles in Issue. `trans_valid_o` and the descriptor stay unchanged, and exactly one `trans_handshake_o` pulse occurs.
- **Timeout.** Set TimeoutCycles=16 and never assert `done_i`. Expect `timeout_o` high exactly 16 cycles after entry to Wait, then Gap, then Idle; the next request is then accepted.
- **Coincidence.** Assert `done_i` in the same cycle as the watchdog limit. Expect `timeout_o=0` and normal Gap entry.
- **Reset mid-Wait.** Assert `rst_i` for one cycle during Wait. The next cycle is Idle with all outputs at reset values, and requester 0 wins the next arbitration.
